// File: rtl/fifo_fill_ctrl_pkg.sv
// Shared definitions for the Minilab0 fill controller and the MAC-side state decoder.
// Contents:
//   fill_state_t - loader FSM state, encoded exactly as it appears on LEDR[1:0]
//   LEDR_*       - LEDR[1:0] codes for each loader state
package fifo_fill_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_t;

  localparam logic [1:0] LEDR_IDLE = 2'd0;
  localparam logic [1:0] LEDR_FILL = 2'd1;
  localparam logic [1:0] LEDR_DONE = 2'd2;

endpackage

// File: rtl/fifo_fill_ctrl_if.sv
// Handshake bundle between the fill controller and its surroundings
// (the FIFOs, the MAC stage and the LED decode).
// Signals:
//   start        request a fill
//   fifo_a_full  FIFO A full
//   fifo_b_full  FIFO B full
//   mac_done     MAC finished consuming
//   wr_a, wr_b   FIFO write strobes (always equal)
//   data_a       FIFO A write data
//   data_b       FIFO B write data
//   fill_count   words written in the current fill
//   fill_done    all DEPTH words written
//   state_o      loader state for LEDR[1:0]
// Modports:
//   master  environment side, drives the requests and the back-pressure
//   slave   controller side
interface fifo_fill_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  start;
  logic                  fifo_a_full;
  logic                  fifo_b_full;
  logic                  mac_done;
  logic                  wr_a;
  logic                  wr_b;
  logic [DATA_WIDTH-1:0] data_a;
  logic [DATA_WIDTH-1:0] data_b;
  logic [CW-1:0]         fill_count;
  logic                  fill_done;
  logic [1:0]            state_o;

  modport master (
    output start, fifo_a_full, fifo_b_full, mac_done,
    input  wr_a, wr_b, data_a, data_b, fill_count, fill_done, state_o
  );

  modport slave (
    input  start, fifo_a_full, fifo_b_full, mac_done,
    output wr_a, wr_b, data_a, data_b, fill_count, fill_done, state_o
  );
endinterface

// File: rtl/fifo_fill_ctrl.sv
// Upstream loader for the Minilab0 MAC datapath. A start pulse in IDLE starts a fill,
// in which DEPTH deterministic words go into FIFO A and FIFO B in lockstep; both
// strobes stall while either FIFO is full. After the last write the block holds
// fill_done in DONE until mac_done, then rearms with the seed values.
// Ports:
//   clk  in   system clock
//   rst  in   synchronous, active-high reset
//   bus  slave modport of fifo_fill_ctrl_if (see that file for the signal list)
module fifo_fill_ctrl
  import fifo_fill_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int SEED_A     = 1,
  parameter int SEED_B     = 1,
  parameter int STEP       = 1
) (
  input  logic             clk,
  input  logic             rst,
  fifo_fill_ctrl_if.slave  bus
);

  localparam int CW = $clog2(DEPTH + 1);

  fill_state_t           state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] data_a_q, data_a_d;
  logic [DATA_WIDTH-1:0] data_b_q, data_b_d;
  logic                  wr_s;

  // A write happens on every FILL cycle in which neither FIFO is full.
  assign wr_s = (state_q == FILL) && !bus.fifo_a_full && !bus.fifo_b_full;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start matters only in IDLE and mac_done only in DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = FILL;
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        // The write that brings the count to DEPTH finishes the fill.
        if (wr_s && (count_q == CW'(DEPTH - 1))) begin
          state_d = DONE;
        end else begin
          state_d = FILL;
        end
      end
      DONE: begin
        if (bus.mac_done) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter and data next values. Addition wraps silently at the data width.
  always_comb begin
    count_d  = count_q;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    if (wr_s) begin
      count_d  = count_q + CW'(1);
      data_a_d = data_a_q + DATA_WIDTH'(STEP);
      data_b_d = data_b_q + DATA_WIDTH'(STEP);
    end else if ((state_q == DONE) && bus.mac_done) begin
      // Rearm so the next fill starts from the seeds.
      count_d  = '0;
      data_a_d = DATA_WIDTH'(SEED_A);
      data_b_d = DATA_WIDTH'(SEED_B);
    end else begin
      count_d  = count_q;
      data_a_d = data_a_q;
      data_b_d = data_b_q;
    end
  end

  // Counter and data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      data_a_q <= DATA_WIDTH'(SEED_A);
      data_b_q <= DATA_WIDTH'(SEED_B);
    end else begin
      count_q  <= count_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
    end
  end

  // Outputs; the strobes are combinational so a full flag stalls the same cycle.
  always_comb begin
    bus.wr_a       = wr_s;
    bus.wr_b       = wr_s;
    bus.data_a     = data_a_q;
    bus.data_b     = data_b_q;
    bus.fill_count = count_q;
    bus.fill_done  = (state_q == DONE);
    case (state_q)
      IDLE:    bus.state_o = LEDR_IDLE;
      FILL:    bus.state_o = LEDR_FILL;
      DONE:    bus.state_o = LEDR_DONE;
      default: bus.state_o = LEDR_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_fill_ctrl.sv
// Self-checking bench for fifo_fill_ctrl. Two instances share one stimulus stream:
// u8 uses the default 8-bit configuration, and u4 is 4 bits wide with SEED_A=14
// so that its data wraps. A cycle-level behavioural model (phase + words written)
// predicts every output, and literal spot checks pin the directed scenarios.
module tb_fifo_fill_ctrl;

  localparam int DEPTH = 8;
  localparam int W8 = 8, SA8 = 1,  SB8 = 1, ST8 = 1;
  localparam int W4 = 4, SA4 = 14, SB4 = 5, ST4 = 1;

  bit clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, fa = 1'b0, fb = 1'b0, md = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_fill_ctrl_if #(.DATA_WIDTH(W8), .DEPTH(DEPTH)) if8 ();
  fifo_fill_ctrl_if #(.DATA_WIDTH(W4), .DEPTH(DEPTH)) if4 ();

  assign if8.start = start;  assign if8.fifo_a_full = fa;
  assign if8.fifo_b_full = fb;  assign if8.mac_done = md;
  assign if4.start = start;  assign if4.fifo_a_full = fa;
  assign if4.fifo_b_full = fb;  assign if4.mac_done = md;

  fifo_fill_ctrl #(.DATA_WIDTH(W8), .DEPTH(DEPTH), .SEED_A(SA8), .SEED_B(SB8), .STEP(ST8))
    u8 (.clk(clk), .rst(rst), .bus(if8.slave));
  fifo_fill_ctrl #(.DATA_WIDTH(W4), .DEPTH(DEPTH), .SEED_A(SA4), .SEED_B(SB4), .STEP(ST4))
    u4 (.clk(clk), .rst(rst), .bus(if4.slave));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_phase: 0 idle, 1 filling, 2 waiting for MAC; m_n: words written this fill.
  int m_phase = 0;
  int m_n = 0;
  bit m_valid = 1'b0;

  function automatic int word(input int seed, input int step, input int n, input int w);
    return (seed + n * step) % (1 << w);
  endfunction

  // Model update on each clock edge from the inputs present during that cycle.
  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0;
      m_n     <= 0;
      m_valid <= 1'b1;
    end else if (m_valid) begin
      case (m_phase)
        0: if (start) m_phase <= 1;
        1: if (!fa && !fb) begin
             m_n <= m_n + 1;
             if (m_n + 1 == DEPTH) m_phase <= 2;
           end
        2: if (md) begin
             m_phase <= 0;
             m_n     <= 0;
           end
        default: m_phase <= 0;
      endcase
    end
  end

  // Compare all outputs of both instances against the model every cycle.
  always @(negedge clk) begin
    if (m_valid) begin
      int wr_exp;
      wr_exp = (m_phase == 1 && !fa && !fb) ? 1 : 0;
      chk("m_wr_a8",   int'(if8.wr_a), wr_exp);
      chk("m_wr_b8",   int'(if8.wr_b), wr_exp);
      chk("m_wr_a4",   int'(if4.wr_a), wr_exp);
      chk("m_wr_b4",   int'(if4.wr_b), wr_exp);
      chk("m_data_a8", int'(if8.data_a), word(SA8, ST8, m_n, W8));
      chk("m_data_b8", int'(if8.data_b), word(SB8, ST8, m_n, W8));
      chk("m_data_a4", int'(if4.data_a), word(SA4, ST4, m_n, W4));
      chk("m_data_b4", int'(if4.data_b), word(SB4, ST4, m_n, W4));
      chk("m_count8",  int'(if8.fill_count), m_n);
      chk("m_count4",  int'(if4.fill_count), m_n);
      chk("m_done8",   int'(if8.fill_done), (m_phase == 2) ? 1 : 0);
      chk("m_done4",   int'(if4.fill_done), (m_phase == 2) ? 1 : 0);
      chk("m_state8",  int'(if8.state_o), m_phase);
      chk("m_state4",  int'(if4.state_o), m_phase);
    end
  end

  // One cycle: drive inputs just after the edge, return at the following negedge.
  task automatic step(input bit s, input bit a, input bit b, input bit m, input bit r);
    @(posedge clk);
    #1;
    start = s; fa = a; fb = b; md = m; rst = r;
    @(negedge clk);
  endtask

  initial begin
    // ---- reset ----
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("rst_state", int'(if8.state_o), 0);
    chk("rst_count", int'(if8.fill_count), 0);
    chk("rst_data_a", int'(if8.data_a), 1);
    chk("rst_data_a4", int'(if4.data_a), 14);
    chk("rst_wr", int'(if8.wr_a), 0);

    // ---- 1: plain fill, 1..8 and wrap on the 4-bit instance ----
    step(1, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      step(0, 0, 0, 0, 0);
      chk("t1_wr", int'(if8.wr_a), 1);
      chk("t1_data_a", int'(if8.data_a), k);
      chk("t1_data_b", int'(if8.data_b), k);
      chk("t3_data_a4", int'(if4.data_a), (14 + k - 1) % 16);
      chk("t1_done_low", int'(if8.fill_done), 0);
    end
    step(0, 0, 0, 0, 0);
    chk("t1_done_c9", int'(if8.fill_done), 1);
    chk("t1_state_c9", int'(if8.state_o), 2);
    chk("t3_count4", int'(if4.fill_count), 8);
    chk("t1_wr_c9", int'(if8.wr_a), 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("t1_back_idle", int'(if8.state_o), 0);

    // ---- 2: FIFO B full in cycles 3-5 ----
    step(1, 0, 0, 0, 0);
    for (int c = 1; c <= 12; c++) begin
      step(0, 0, (c >= 3 && c <= 5), 0, 0);
      if (c >= 3 && c <= 5) chk("t2_stall_wr", int'(if8.wr_a), 0);
      if (c == 6) chk("t2_resume_data", int'(if8.data_a), 3);
      if (c == 11) chk("t2_last_data", int'(if8.data_a), 8);
      if (c == 11) chk("t2_done_c11", int'(if8.fill_done), 0);
      if (c == 12) chk("t2_done_c12", int'(if8.fill_done), 1);
    end
    step(0, 0, 0, 1, 0);

    // ---- 4: start ignored in FILL and DONE ----
    step(1, 0, 0, 0, 0);
    for (int c = 1; c <= 8; c++) step((c == 3), 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t4_hold_state", int'(if8.state_o), 2);
    chk("t4_hold_count", int'(if8.fill_count), 8);
    chk("t4_hold_data", int'(if8.data_a), 9);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("t4_idle", int'(if8.state_o), 0);
    chk("t4_count0", int'(if8.fill_count), 0);

    // ---- 5: reset after the 4th write ----
    step(1, 0, 0, 0, 0);
    for (int c = 1; c <= 4; c++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("t5_state", int'(if8.state_o), 0);
    chk("t5_wr", int'(if8.wr_a), 0);
    chk("t5_count", int'(if8.fill_count), 0);
    chk("t5_data", int'(if8.data_a), 1);
    step(1, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      step(0, 0, 0, 0, 0);
      chk("t5_refill", int'(if8.data_a), k);
    end

    // ---- 6: start and mac_done together in DONE ----
    step(1, 0, 0, 1, 0);
    for (int c = 1; c <= 3; c++) begin
      step(0, 0, 0, 0, 0);
      chk("t6_state", int'(if8.state_o), 0);
      chk("t6_wr", int'(if8.wr_a), 0);
    end

    // ---- random traffic, model-checked ----
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 4) == 0, ($urandom % 4) == 0, ($urandom % 4) == 0,
           ($urandom % 3) == 0, ($urandom % 80) == 0);
    end

    step(0, 0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
